match_sequencer: RTL

Controller that sequences the SIFT descriptor-matching datapath. For each query feature it streams every scene descriptor address into the distance unit and drives the ratio-test comparator's enable, index and end-of-row strobes. It collects the comparator's per-query verdict and queues accepted (query, scene) index pairs in an output FIFO for the host or readout logic. It sits between the descriptor memories and the comparator, and owns start/busy/done for a matching run.

---
 rtl/match_pkg.sv | 22 ++
 rtl/match_fifo.sv | 52 +++++
 rtl/match_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/match_pkg.sv
// Shared types and constants for the descriptor-matching sequencer.
package match_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    WAIT_RES,
    PUSH,
    FINISH
  } state_t;

  localparam int DIST_W = 17;
  localparam int DEF_QW = 10;
  localparam int DEF_SW = 11;

  typedef struct packed {
    logic [DEF_QW-1:0] qidx;
    logic [DEF_SW-1:0] sidx;
  } match_entry_t;

endpackage

// File: rtl/match_fifo.sv
// First-word fall-through synchronous FIFO holding accepted (query, scene) pairs.
module match_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 21
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  // A read frees a slot on the same edge, so a full FIFO still accepts a write then.
  assign w_wr    = i_wr_en && (!o_full || i_rd_en);
  assign w_rd    = i_rd_en && !o_empty;
  assign o_rd_data = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/match_sequencer.sv
// Sequences SIFT descriptor matching: issues scene reads per query, collects verdicts, queues matches.
// Optional build macro MATCH_TIMEOUT_EN adds a WAIT_RES timeout and the sticky timeout_err output.
module match_sequencer
  import match_pkg::*;
#(
  parameter int QW         = DEF_QW,
  parameter int SW         = DEF_SW,
  parameter int DIST_LAT   = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic          iclk,
  input  logic          irst,
  input  logic          istart,
  input  logic [QW-1:0] nq,
  input  logic [SW-1:0] ns,
  output logic          rd_en,
  output logic [QW-1:0] q_addr,
  output logic [SW-1:0] s_addr,
  output logic          cmp_en,
  output logic [SW-1:0] cmp_idx,
  output logic          cmp_last,
  input  logic          cmp_res_valid,
  input  logic          cmp_match,
  input  logic [SW-1:0] cmp_match_idx,
  output logic          m_valid,
  output logic [QW-1:0] m_qidx,
  output logic [SW-1:0] m_sidx,
  input  logic          m_ready,
  output logic          busy,
  output logic          done
`ifdef MATCH_TIMEOUT_EN
  ,
  output logic          timeout_err
`endif
);

  state_t        r_state;
  logic [QW-1:0] r_nq;
  logic [SW-1:0] r_ns;
  logic          r_match;
  logic [SW-1:0] r_midx;

  logic          r_dl_v    [DIST_LAT];
  logic [SW-1:0] r_dl_idx  [DIST_LAT];
  logic          r_dl_last [DIST_LAT];

  logic             w_issue_last;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_stall;
  logic [QW+SW-1:0] w_rd_data;

`ifdef MATCH_TIMEOUT_EN
  logic [3:0] r_to_cnt;
`endif

  assign w_issue_last = (r_state == ISSUE) && (s_addr == r_ns - SW'(1));
  assign w_pop        = m_ready && !w_empty;
  assign w_stall      = r_match && w_full && !w_pop;
  assign w_push       = (r_state == PUSH) && r_match && !w_stall;

  assign m_valid            = !w_empty;
  assign {m_qidx, m_sidx}   = w_rd_data;
  assign cmp_en             = r_dl_v[DIST_LAT-1];
  assign cmp_idx            = r_dl_idx[DIST_LAT-1];
  assign cmp_last           = r_dl_last[DIST_LAT-1];

  // Models the distance-unit latency so comparator strobes line up with each pair's distance.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      for (int i = 0; i < DIST_LAT; i++) begin
        r_dl_v[i]    <= 1'b0;
        r_dl_idx[i]  <= '0;
        r_dl_last[i] <= 1'b0;
      end
    end else begin
      r_dl_v[0]    <= rd_en;
      r_dl_idx[0]  <= rd_en ? s_addr : '0;
      r_dl_last[0] <= w_issue_last;
      for (int i = 1; i < DIST_LAT; i++) begin
        r_dl_v[i]    <= r_dl_v[i-1];
        r_dl_idx[i]  <= r_dl_idx[i-1];
        r_dl_last[i] <= r_dl_last[i-1];
      end
    end
  end

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      r_state <= IDLE;
      r_nq    <= '0;
      r_ns    <= '0;
      r_match <= 1'b0;
      r_midx  <= '0;
      rd_en   <= 1'b0;
      q_addr  <= '0;
      s_addr  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef MATCH_TIMEOUT_EN
      r_to_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (istart) begin
            r_nq   <= nq;
            r_ns   <= ns;
            q_addr <= '0;
            s_addr <= '0;
            busy   <= 1'b1;
`ifdef MATCH_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            if (nq == '0 || ns == '0) begin
              r_state <= FINISH;
              done    <= 1'b1;
            end else begin
              r_state <= ISSUE;
              rd_en   <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (w_issue_last) begin
            rd_en   <= 1'b0;
            r_state <= DRAIN;
          end else begin
            s_addr <= s_addr + SW'(1);
          end
        end
        DRAIN: begin
          if (cmp_last) begin
            r_state <= WAIT_RES;
`ifdef MATCH_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
          end
        end
        WAIT_RES: begin
          if (cmp_res_valid) begin
            r_match <= cmp_match;
            r_midx  <= cmp_match_idx;
            r_state <= PUSH;
          end
`ifdef MATCH_TIMEOUT_EN
          // Fifteenth silent cycle: give up on this row as a non-match.
          else if (r_to_cnt == 4'd14) begin
            r_match     <= 1'b0;
            timeout_err <= 1'b1;
            r_state     <= PUSH;
          end else begin
            r_to_cnt <= r_to_cnt + 4'd1;
          end
`endif
        end
        PUSH: begin
          if (!w_stall) begin
            if (q_addr == r_nq - QW'(1)) begin
              r_state <= FINISH;
              done    <= 1'b1;
            end else begin
              q_addr  <= q_addr + QW'(1);
              s_addr  <= '0;
              rd_en   <= 1'b1;
              r_state <= ISSUE;
            end
          end
        end
        FINISH: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  match_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (QW + SW)
  ) u_fifo (
    .i_clk     (iclk),
    .i_rst_n   (irst),
    .i_wr_en   (w_push),
    .i_wr_data ({q_addr, r_midx}),
    .i_rd_en   (w_pop),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

endmodule
